clap_event_detector: RTL and testbench

//  Producer side of the clap-count interface: turns the FFT magnitude stream into clean clap events.
//  - Consumes one unsigned magnitude sample per mag_valid strobe from the FFT/abs stage.
//  - Emits exactly one single-cycle clap_pulse per physical clap, using hysteresis, a minimum-width

---
 rtl/clap_event_detector_if.sv | 24 ++
 rtl/clap_event_detector.sv | 102 ++++++++++
 tb/tb_clap_event_detector.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/clap_event_detector_if.sv
// Magnitude sample stream in, clap events out.
// The event side is producer-driven and has no ready; a listener must sample every cycle.
interface clap_event_detector_if #(
    parameter int DATA_W = 16
);
    logic              mag_valid;
    logic [DATA_W-1:0] mag;
    logic              clap_pulse;
    logic [3:0]        clap_count;

    modport master (
        output mag_valid,
        output mag,
        input  clap_pulse,
        input  clap_count
    );

    modport slave (
        input  mag_valid,
        input  mag,
        output clap_pulse,
        output clap_count
    );
endinterface

// File: rtl/clap_event_detector.sv
// Turns the FFT magnitude stream into one clap_pulse per clap: hysteresis, width filter, holdoff.
// Pulse appears one cycle after the sample that completes MIN_WIDTH; there is no backpressure, mag_valid gates all progress.
module clap_event_detector #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] THRESH_HI = 16'h8000,
    parameter logic [DATA_W-1:0] THRESH_LO = 16'h4000,
    parameter int                MIN_WIDTH = 4,
    parameter int                HOLDOFF   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    clap_event_detector_if.slave bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    localparam int WW = $clog2(MIN_WIDTH + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [WW-1:0] MIN_W    = WW'(MIN_WIDTH);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [WW-1:0] width_cnt;
    logic [HW-1:0] hold_cnt;
    logic          loud_hi;
    logic          loud_lo;
    logic [WW-1:0] width_nxt;

    assign loud_hi   = (bus.mag >= THRESH_HI);
    assign loud_lo   = (bus.mag >= THRESH_LO);
    assign width_nxt = width_cnt + WW'(1);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            width_cnt      <= '0;
            hold_cnt       <= '0;
            bus.clap_pulse <= 1'b0;
            bus.clap_count <= 4'd0;
            busy           <= 1'b0;
        end else begin
            bus.clap_pulse <= 1'b0;
            if (bus.mag_valid) begin
                case (state)
                    IDLE: begin
                        if (loud_hi) begin
                            if (MIN_WIDTH == 1) begin
                                state          <= HOLD;
                                hold_cnt       <= '0;
                                width_cnt      <= '0;
                                bus.clap_pulse <= 1'b1;
                                bus.clap_count <= bus.clap_count + 4'd1;
                            end else begin
                                state     <= ARM;
                                width_cnt <= WW'(1);
                            end
                            busy <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (!loud_lo) begin
                            // Too short to be a clap: drop it silently.
                            state     <= IDLE;
                            width_cnt <= '0;
                            busy      <= 1'b0;
                        end else if (width_nxt == MIN_W) begin
                            state          <= HOLD;
                            width_cnt      <= '0;
                            hold_cnt       <= '0;
                            bus.clap_pulse <= 1'b1;
                            bus.clap_count <= bus.clap_count + 4'd1;
                        end else begin
                            width_cnt <= width_nxt;
                        end
                    end
                    HOLD: begin
                        // A tone that stays loud keeps us here indefinitely, so it cannot re-trigger.
                        if (hold_cnt == HOLD_MAX && !loud_lo) begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                            busy     <= 1'b0;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        width_cnt <= '0;
                        hold_cnt  <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clap_event_detector.sv
// Scoreboarded bench: directed clap scenarios followed by randomized streams against a sample-level model.
module tb_clap_event_detector;
    localparam logic [15:0] HI = 16'h8000;
    localparam logic [15:0] LO = 16'h4000;
    localparam int          MW = 4;
    localparam int          HO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [1:0] state_dbg;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    clap_event_detector_if #(.DATA_W(16)) bus ();

    clap_event_detector #(.HOLDOFF(HO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    exp_t sb[$];

    // Reference: length of the current loud run, whether we are in holdoff and how many samples it has seen.
    int m_run = 0;
    bit m_hold = 0;
    int m_hold_n = 0;
    int m_count = 0;

    function automatic int exp_state();
        return m_hold ? 2 : (m_run > 0 ? 1 : 0);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic accept();
        m_hold   = 1;
        m_hold_n = 0;
        m_run    = 0;
        m_count  = (m_count + 1) % 16;
        sb.push_back('{cyc: cyc, cnt: m_count});
    endtask

    task automatic model(input logic r, input logic v, input logic [15:0] m);
        if (r) begin
            m_run = 0; m_hold = 0; m_hold_n = 0; m_count = 0;
        end else if (v) begin
            if (m_hold) begin
                if (m_hold_n >= HO && m < LO) m_hold = 0;
                else if (m_hold_n < HO) m_hold_n++;
            end else if (m_run == 0) begin
                if (m >= HI) begin
                    m_run = 1;
                    if (m_run >= MW) accept();
                end
            end else if (m >= LO) begin
                m_run++;
                if (m_run >= MW) accept();
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] m);
        @(negedge clk);
        rst = r;
        bus.mag_valid = v;
        bus.mag = m;
        @(posedge clk);
        #1;
        model(r, v, m);
        chk("state_dbg", int'(state_dbg), exp_state());
        chk("busy", int'(busy), int'(exp_state() != 0));
        chk("clap_count", int'(bus.clap_count), m_count);
    endtask

    task automatic clap(input int loud, input int quiet);
        for (int i = 0; i < loud; i++) step(1'b0, 1'b1, 16'hFFFF);
        for (int i = 0; i < quiet; i++) step(1'b0, 1'b1, 16'h0000);
    endtask

    always @(negedge clk) begin
        if (bus.clap_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_pulse cyc=%0d got=pulse expected=none count=%0d", cyc, bus.clap_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_count", int'(bus.clap_count), e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq2 [5];
        int burst;
        int r;
        logic [15:0] m;
        rst = 1'b1;
        bus.mag_valid = 1'b0;
        bus.mag = 16'h0000;

        // Reset dominates a loud valid sample.
        step(1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 16'hFFFF);
        chk("t1_count", int'(bus.clap_count), 0);
        chk("t1_pulse", int'(bus.clap_pulse), 0);

        // Onset at exactly HI, sustain at exactly LO.
        seq2 = '{16'h8000, 16'h9000, 16'h4000, 16'h4000, 16'h0000};
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, seq2[i]);
        chk("t2_count", int'(bus.clap_count), 1);
        chk("t2_state", int'(state_dbg), 2);
        clap(0, 12);
        chk("t2_idle", int'(state_dbg), 0);

        // Glitch just under LO.
        step(1'b0, 1'b1, 16'h8000);
        step(1'b0, 1'b1, 16'h8000);
        step(1'b0, 1'b1, 16'h3FFF);
        chk("t3_state", int'(state_dbg), 0);
        chk("t3_count", int'(bus.clap_count), 1);

        // Sustained tone: one pulse, held until a quiet sample after holdoff.
        clap(40, 0);
        chk("t4_count", int'(bus.clap_count), 2);
        chk("t4_hold", int'(state_dbg), 2);
        step(1'b0, 1'b1, 16'h0000);
        chk("t4_exit", int'(state_dbg), 0);

        // Counter wrap.
        step(1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 17; k++) clap(4, 12);
        chk("t5_wrap", int'(bus.clap_count), 1);

        // Sparse valids, then reset mid-ARM.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, (i == 1) ? 16'h9000 : 16'h8000);
            step(1'b0, 1'b0, 16'h0000);
        end
        step(1'b0, 1'b0, 16'hFFFF);
        chk("t6_count", int'(bus.clap_count), 1);
        clap(0, 12);
        step(1'b0, 1'b1, 16'h8000);
        step(1'b0, 1'b1, 16'h8000);
        step(1'b1, 1'b1, 16'h8000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk("t6_rst_count", int'(bus.clap_count), 0);
        chk("t6_rst_state", int'(state_dbg), 0);

        // Random streams biased towards the threshold edges.
        burst = 0;
        for (int n = 0; n < 2500; n++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 7);
            if (burst > 0) begin
                m = 16'($urandom_range(16'h4000, 16'hFFFF));
                burst--;
            end else begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2, 3: m = 16'($urandom_range(0, 16'h3FFF));
                    4: m = 16'h3FFF;
                    5: m = 16'h4000;
                    6: m = 16'h7FFF;
                    7: m = 16'h8000;
                    default: m = 16'($urandom_range(16'h8000, 16'hFFFF));
                endcase
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), m);
        end

        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk("pending_pulses", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
